// File: rtl/id_operand_stage.sv
// -----------------------------------------------------------------------------
// id_operand_stage
//   Decode-issue pipeline stage. Latches one decoded instruction from IPD,
//   reads its two source operands from the register file and resolves each one
//   through an FWD_N-deep bypass network in which the youngest producer wins.
//   The stage stalls on load-use, drops its instruction on a branch flush from
//   EXE, and hands the payload and resolved operands to EXE under a
//   valid/allow_in handshake.
//
// Optional feature macro: ID_STALL_CNT_EN
//   When defined, the stage adds a saturating 32-bit count of hazard stall
//   cycles on port stall_cnt. When undefined, that port and its logic are absent.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid/in_payload  incoming decoded instruction from IPD
//   in_raddr1/2          source register indices of the incoming instruction
//   id_allow_in          stage can accept an instruction this cycle
//   rf_raddr1/2          RF read addresses, taken from the latched instruction
//   rf_rdata1/2          combinational RF read data
//   fwd_we/addr/data     bypass producers; slice i is producer i, 0 = youngest
//   fwd_data_ok          producer i result available (0 = load still in flight)
//   flush                branch cancel from EXE
//   exe_allow_in         EXE can accept
//   out_valid            ID->EXE valid
//   out_payload          latched payload
//   out_src1/2           resolved operands
//   stall_cnt            stall cycle counter (ID_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module id_operand_stage #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned RADDR_W   = 5,
   parameter int unsigned PAYLOAD_W = 112,
   parameter int unsigned FWD_N     = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       id_allow_in,
   input  logic [PAYLOAD_W-1:0]       in_payload,
   input  logic [RADDR_W-1:0]         in_raddr1,
   input  logic [RADDR_W-1:0]         in_raddr2,
   output logic [RADDR_W-1:0]         rf_raddr1,
   output logic [RADDR_W-1:0]         rf_raddr2,
   input  logic [DATA_W-1:0]          rf_rdata1,
   input  logic [DATA_W-1:0]          rf_rdata2,
   input  logic [FWD_N-1:0]           fwd_we,
   input  logic [FWD_N*RADDR_W-1:0]   fwd_addr,
   input  logic [FWD_N*DATA_W-1:0]    fwd_data,
   input  logic [FWD_N-1:0]           fwd_data_ok,
   input  logic                       flush,
   input  logic                       exe_allow_in,
   output logic                       out_valid,
   output logic [PAYLOAD_W-1:0]       out_payload,
   output logic [DATA_W-1:0]          out_src1,
`ifdef ID_STALL_CNT_EN
   output logic [31:0]                stall_cnt,
`endif
   output logic [DATA_W-1:0]          out_src2
);

   logic                 id_valid_q, id_valid_d;
   logic [PAYLOAD_W-1:0] payload_q,  payload_d;
   logic [RADDR_W-1:0]   raddr1_q,   raddr1_d;
   logic [RADDR_W-1:0]   raddr2_q,   raddr2_d;

   logic [DATA_W-1:0]    src1_val, src2_val;
   logic                 src1_wait, src2_wait;
   logic                 hazard;
   logic                 id_ready_go;

   // Returns {wait, data}. The first (youngest) matching producer is selected
   // and its ok bit alone decides the wait; older matches are never consulted.
   // Register 0 reads as zero and never waits.
   function automatic logic [DATA_W:0] resolve(
      input logic [RADDR_W-1:0]       raddr,
      input logic [DATA_W-1:0]        rf_data,
      input logic [FWD_N-1:0]         we,
      input logic [FWD_N*RADDR_W-1:0] addr,
      input logic [FWD_N*DATA_W-1:0]  data,
      input logic [FWD_N-1:0]         ok
   );
      logic [DATA_W-1:0] val;
      logic              hit;
      logic              wt;
      val = rf_data;
      hit = 1'b0;
      wt  = 1'b0;
      for (int unsigned i = 0; i < FWD_N; i++) begin
         if (!hit && we[i] && (addr[i*RADDR_W +: RADDR_W] == raddr)) begin
            hit = 1'b1;
            wt  = ~ok[i];
            val = data[i*DATA_W +: DATA_W];
         end
      end
      if (raddr == '0) begin
         val = '0;
         wt  = 1'b0;
      end
      return {wt, val};
   endfunction

   always_comb begin
      {src1_wait, src1_val} = resolve(raddr1_q, rf_rdata1, fwd_we, fwd_addr,
                                      fwd_data, fwd_data_ok);
      {src2_wait, src2_val} = resolve(raddr2_q, rf_rdata2, fwd_we, fwd_addr,
                                      fwd_data, fwd_data_ok);
   end

   assign hazard      = id_valid_q & (src1_wait | src2_wait);
   assign id_ready_go = ~hazard;
   assign id_allow_in = ~id_valid_q | (id_ready_go & exe_allow_in);
   assign out_valid   = id_valid_q & id_ready_go;
   assign out_payload = payload_q;
   assign out_src1    = src1_val;
   assign out_src2    = src2_val;
   assign rf_raddr1   = raddr1_q;
   assign rf_raddr2   = raddr2_q;

   // Flush takes priority: the held instruction is cancelled and any
   // instruction offered in the same cycle is dropped without being latched.
   always_comb begin
      id_valid_d = id_valid_q;
      payload_d  = payload_q;
      raddr1_d   = raddr1_q;
      raddr2_d   = raddr2_q;
      if (flush) begin
         id_valid_d = 1'b0;
      end else if (id_allow_in) begin
         id_valid_d = in_valid;
         if (in_valid) begin
            payload_d = in_payload;
            raddr1_d  = in_raddr1;
            raddr2_d  = in_raddr2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid_q <= 1'b0;
         payload_q  <= '0;
         raddr1_q   <= '0;
         raddr2_q   <= '0;
      end else begin
         id_valid_q <= id_valid_d;
         payload_q  <= payload_d;
         raddr1_q   <= raddr1_d;
         raddr2_q   <= raddr2_d;
      end
   end

`ifdef ID_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hazard && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
